// File: rtl/sobel_multi_channel_filter.sv
// Streaming multi-channel Sobel edge filter.
// Two previous image rows live in a synchronous 1R1W RAM; a 3x2 register window
// per channel combines with the RAM column and the incoming pixel to form the
// full 3x3 neighbourhood. Output is |Gx|+|Gy| saturated, borders forced to zero.

module ram_1r1w_sync #(
    parameter int WIDTH_P = 8,
    parameter int DEPTH_P = 4
) (
    input  logic                       clk_i,
    input  logic                       w_v_i,
    input  logic [$clog2(DEPTH_P)-1:0] w_addr_i,
    input  logic [WIDTH_P-1:0]         w_data_i,
    input  logic [$clog2(DEPTH_P)-1:0] r_addr_i,
    output logic [WIDTH_P-1:0]         r_data_o
);

    logic [WIDTH_P-1:0] mem_q [DEPTH_P];
    logic [WIDTH_P-1:0] r_data_q;

    // Write port and registered read port; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
        r_data_q <= mem_q[r_addr_i];
    end

    assign r_data_o = r_data_q;

endmodule

module sobel_multi_channel_filter #(
    parameter int WIDTH_P      = 10,
    parameter int HEIGHT_P     = 10,
    parameter int CHANNELS_P   = 3,
    parameter int PIXEL_BITS_P = 8
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    input  logic [CHANNELS_P*PIXEL_BITS_P-1:0] pixels_i,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic [CHANNELS_P*PIXEL_BITS_P-1:0] pixels_o,
    output logic                               last_o
);

    localparam int PB  = PIXEL_BITS_P;
    localparam int BUS = CHANNELS_P * PIXEL_BITS_P;
    localparam int AW  = $clog2(WIDTH_P);
    localparam int RW  = $clog2(HEIGHT_P);
    localparam int DW  = $clog2(WIDTH_P + 2);
    localparam int S   = PIXEL_BITS_P + 4;

    localparam logic [AW-1:0]       COL_LAST  = AW'(WIDTH_P - 1);
    localparam logic [RW-1:0]       ROW_LAST  = RW'(HEIGHT_P - 1);
    localparam logic [DW-1:0]       DRAIN_LEN = DW'(WIDTH_P + 1);
    localparam logic signed [S-1:0] SAT       = $signed({4'b0000, {PB{1'b1}}});

    typedef enum logic [1:0] {
        LOAD,
        STREAM,
        DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic [BUS-1:0]  pix_q, pix_d;

    // Window per channel: index 0 = top row, 1 = middle row, 2 = bottom row.
    logic [PB-1:0]   win_l_q [CHANNELS_P][3];
    logic [PB-1:0]   win_l_d [CHANNELS_P][3];
    logic [PB-1:0]   win_c_q [CHANNELS_P][3];
    logic [PB-1:0]   win_c_d [CHANNELS_P][3];

    // RAM word: upper half = row above current, lower half = two rows above.
    logic [2*BUS-1:0] rd_data;
    logic [AW-1:0]    rd_addr;
    logic [BUS-1:0]   sobel_pix;
    logic             accept;
    logic             out_xfer;
    logic             border;
    logic             last_in;

    function automatic logic signed [S-1:0] ext(input logic [PB-1:0] p);
        return $signed({4'b0000, p});
    endfunction

    function automatic logic [PB-1:0] sobel_mag(
        input logic [PB-1:0] tl, tc, tr, ml, mr, bl, bc, br
    );
        logic signed [S-1:0] gx, gy, sum;
        gx = (ext(tr) + (ext(mr) <<< 1) + ext(br)) - (ext(tl) + (ext(ml) <<< 1) + ext(bl));
        gy = (ext(bl) + (ext(bc) <<< 1) + ext(br)) - (ext(tl) + (ext(tc) <<< 1) + ext(tr));
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        sum = gx + gy;
        return (sum > SAT) ? '1 : sum[PB-1:0];
    endfunction

    assign ready_o  = !reset_i && (state_q != DRAIN) && (!valid_q || ready_i);
    assign valid_o  = valid_q && !reset_i;
    assign last_o   = last_q && !reset_i;
    assign pixels_o = reset_i ? '0 : pix_q;
    assign accept   = valid_i && ready_o;
    assign out_xfer = valid_o && ready_i;

    // The accepted pixel is the bottom-right of the output neighbourhood, so the
    // output column is one left of it; columns 0/1 and input row 1 map to borders.
    assign border  = (col_q <= AW'(1)) || (row_q == RW'(1));
    assign last_in = (col_q == COL_LAST) && (row_q == ROW_LAST);

    // Read address follows the next expected column, so it only moves on accept.
    assign rd_addr = reset_i ? '0 : col_d;

    ram_1r1w_sync #(
        .WIDTH_P (2 * BUS),
        .DEPTH_P (WIDTH_P)
    ) u_ram (
        .clk_i    (clk_i),
        .w_v_i    (accept),
        .w_addr_i (col_q),
        .w_data_i ({pixels_i, rd_data[BUS +: BUS]}),
        .r_addr_i (rd_addr),
        .r_data_o (rd_data)
    );

    // Per-channel gradient magnitude for the neighbourhood completed by pixels_i.
    always_comb begin
        sobel_pix = '0;
        for (int unsigned ch = 0; ch < CHANNELS_P; ch++) begin
            sobel_pix[ch*PB +: PB] = sobel_mag(
                win_l_q[ch][0], win_c_q[ch][0], rd_data[ch*PB +: PB],
                win_l_q[ch][1],                 rd_data[BUS + ch*PB +: PB],
                win_l_q[ch][2], win_c_q[ch][2], pixels_i[ch*PB +: PB]);
        end
    end

    // Next-state logic for the controller, counters, window and output register.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        drain_d = drain_q;
        valid_d = valid_q;
        last_d  = last_q;
        pix_d   = pix_q;
        win_l_d = win_l_q;
        win_c_d = win_c_q;

        case (state_q)
            LOAD, STREAM: begin
                if (out_xfer) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
                if (accept) begin
                    for (int unsigned ch = 0; ch < CHANNELS_P; ch++) begin
                        win_l_d[ch]    = win_c_q[ch];
                        win_c_d[ch][0] = rd_data[ch*PB +: PB];
                        win_c_d[ch][1] = rd_data[BUS + ch*PB +: PB];
                        win_c_d[ch][2] = pixels_i[ch*PB +: PB];
                    end
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
                    end else begin
                        col_d = col_q + AW'(1);
                    end
                    if (state_q == LOAD) begin
                        if ((row_q == RW'(1)) && (col_q == '0)) begin
                            state_d = STREAM;
                        end
                    end else begin
                        valid_d = 1'b1;
                        last_d  = 1'b0;
                        pix_d   = border ? '0 : sobel_pix;
                        if (last_in) begin
                            state_d = DRAIN;
                            drain_d = DRAIN_LEN;
                        end
                    end
                end
            end
            DRAIN: begin
                // Remaining outputs are the right column of row H-2 and all of
                // row H-1, so every drained pixel is a zero border pixel.
                if (!valid_q || ready_i) begin
                    if (valid_q && last_q) begin
                        state_d = LOAD;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else if (drain_q != '0) begin
                        valid_d = 1'b1;
                        pix_d   = '0;
                        last_d  = (drain_q == DW'(1));
                        drain_d = drain_q - DW'(1);
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= LOAD;
            col_q   <= '0;
            row_q   <= '0;
            drain_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            pix_q   <= '0;
            for (int unsigned ch = 0; ch < CHANNELS_P; ch++) begin
                for (int unsigned r = 0; r < 3; r++) begin
                    win_l_q[ch][r] <= '0;
                    win_c_q[ch][r] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            drain_q <= drain_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            pix_q   <= pix_d;
            win_l_q <= win_l_d;
            win_c_q <= win_c_d;
        end
    end

endmodule

// File: tb/tb_sobel_multi_channel_filter.sv
// Self-checking bench: a 4x4 and a 5x4 instance share the stimulus signals; a
// plain-arithmetic Sobel model computes every expected output frame.

module tb_sobel_multi_channel_filter;

    localparam int CH  = 2;
    localparam int PB  = 8;
    localparam int BUS = CH * PB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_i;
    logic           valid_i;
    logic           ready_i;
    logic [BUS-1:0] pixels_i;
    int             sel;

    logic           v4_i, r4_i, rdy4, vo4, lo4;
    logic           v5_i, r5_i, rdy5, vo5, lo5;
    logic [BUS-1:0] po4, po5;

    logic           ready_o, valid_o, last_o;
    logic [BUS-1:0] pixels_o;

    assign v4_i = valid_i && (sel == 0);
    assign r4_i = ready_i && (sel == 0);
    assign v5_i = valid_i && (sel == 1);
    assign r5_i = ready_i && (sel == 1);

    assign ready_o  = (sel == 1) ? rdy5 : rdy4;
    assign valid_o  = (sel == 1) ? vo5  : vo4;
    assign last_o   = (sel == 1) ? lo5  : lo4;
    assign pixels_o = (sel == 1) ? po5  : po4;

    sobel_multi_channel_filter #(
        .WIDTH_P      (4),
        .HEIGHT_P     (4),
        .CHANNELS_P   (CH),
        .PIXEL_BITS_P (PB)
    ) dut4 (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .valid_i  (v4_i),
        .ready_o  (rdy4),
        .pixels_i (pixels_i),
        .valid_o  (vo4),
        .ready_i  (r4_i),
        .pixels_o (po4),
        .last_o   (lo4)
    );

    sobel_multi_channel_filter #(
        .WIDTH_P      (5),
        .HEIGHT_P     (4),
        .CHANNELS_P   (CH),
        .PIXEL_BITS_P (PB)
    ) dut5 (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .valid_i  (v5_i),
        .ready_o  (rdy5),
        .pixels_i (pixels_i),
        .valid_o  (vo5),
        .ready_i  (r5_i),
        .pixels_o (po5),
        .last_o   (lo5)
    );

    int             tests = 0;
    int             fails = 0;
    int             fw, fh;
    logic [7:0]     fpx  [64][CH];
    logic [BUS-1:0] expq [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int px(input int r, input int c, input int ch);
        return int'(fpx[r*fw + c][ch]);
    endfunction

    // Reference: direct 3x3 Sobel on the stored frame.
    function automatic void build_expected();
        int wt [3];
        int gx, gy, m;
        wt[0] = 1; wt[1] = 2; wt[2] = 1;
        for (int r = 0; r < fh; r++) begin
            for (int c = 0; c < fw; c++) begin
                expq[r*fw + c] = '0;
                if (r > 0 && r < fh - 1 && c > 0 && c < fw - 1) begin
                    for (int ch = 0; ch < CH; ch++) begin
                        gx = 0;
                        gy = 0;
                        for (int i = 0; i < 3; i++) begin
                            gx += wt[i] * (px(r - 1 + i, c + 1, ch) - px(r - 1 + i, c - 1, ch));
                            gy += wt[i] * (px(r + 1, c - 1 + i, ch) - px(r - 1, c - 1 + i, ch));
                        end
                        if (gx < 0) gx = -gx;
                        if (gy < 0) gy = -gy;
                        m = imin(gx + gy, 255);
                        expq[r*fw + c][ch*PB +: PB] = 8'(m);
                    end
                end
            end
        end
    endfunction

    // kind 0: constant 100; 1: left two columns 0, rest 255; 2: ch0 = 10*col, ch1 = 77; 3: random.
    function automatic void set_frame(input int kind);
        for (int r = 0; r < fh; r++) begin
            for (int c = 0; c < fw; c++) begin
                for (int ch = 0; ch < CH; ch++) begin
                    case (kind)
                        0:       fpx[r*fw + c][ch] = 8'd100;
                        1:       fpx[r*fw + c][ch] = (c < 2) ? 8'd0 : 8'd255;
                        2:       fpx[r*fw + c][ch] = (ch == 0) ? 8'(10 * c) : 8'd77;
                        default: fpx[r*fw + c][ch] = 8'($urandom_range(255));
                    endcase
                end
            end
        end
    endfunction

    task automatic do_reset(input int cycles);
        @(posedge clk); #1;
        reset_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        repeat (cycles) begin
            @(posedge clk); #1;
            check("rst_valid", valid_o, 0);
            check("rst_last", last_o, 0);
            check("rst_pixels", pixels_o, 0);
            check("rst_ready", ready_o, 0);
        end
        reset_i = 1'b0;
        #1;
        check("post_rst_ready", ready_o, 1);
        check("post_rst_valid", valid_o, 0);
    endtask

    task automatic feed_partial(input int n);
        int cnt = 0;
        int cyc = 0;
        while (cnt < n && cyc < 200) begin
            @(posedge clk); #1;
            valid_i  = 1'b1;
            ready_i  = 1'b1;
            pixels_i = BUS'($urandom);
            #1;
            if (ready_o) cnt++;
            cyc++;
        end
        check("partial_fed", cnt, n);
    endtask

    task automatic run_frame(input bit full, input bit first_ready, input int vprob, input int rprob);
        int             n;
        int             in_idx  = 0;
        int             out_idx = 0;
        int             cyc     = 0;
        bit             hold    = 0;
        logic [BUS-1:0] held_pix = '0;
        logic           held_last = 1'b0;
        n = fw * fh;
        build_expected();
        while (out_idx < n && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            valid_i  = (in_idx < n) && ($urandom_range(99) < vprob);
            pixels_i = '0;
            if (in_idx < n) pixels_i = {fpx[in_idx][1], fpx[in_idx][0]};
            ready_i  = ($urandom_range(99) < rprob);
            #1;
            if (first_ready && cyc == 1) check("first_ready", ready_o, 1);
            if (hold) begin
                check("hold_valid", valid_o, 1);
                check("hold_pixels", pixels_o, held_pix);
                check("hold_last", last_o, held_last);
            end
            if (valid_o && ready_i) begin
                check("pixels", pixels_o, expq[out_idx]);
                check("last", last_o, out_idx == n - 1);
                if (full) check("latency", in_idx, imin(out_idx + fw + 2, n));
                if (in_idx == n) check("drain_ready", ready_o, 0);
            end
            hold      = valid_o && !ready_i;
            held_pix  = pixels_o;
            held_last = last_o;
            if (valid_o && ready_i) out_idx++;
            if (valid_i && ready_o) in_idx++;
        end
        check("frame_outputs", out_idx, n);
        check("frame_inputs", in_idx, n);
    endtask

    initial begin
        sel      = 0;
        fw       = 4;
        fh       = 4;
        reset_i  = 1'b1;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        pixels_i = '0;

        do_reset(3);

        // Flat frame, then a back-to-back step-edge frame at full throughput.
        set_frame(0);
        run_frame(1'b1, 1'b0, 100, 100);
        set_frame(1);
        run_frame(1'b1, 1'b1, 100, 100);

        // Horizontal ramp on ch0, flat ch1, with some stalls.
        set_frame(2);
        run_frame(1'b0, 1'b1, 70, 70);

        // Abort a frame after 7 inputs, then a clean frame; repeat it from reset.
        feed_partial(7);
        do_reset(2);
        set_frame(3);
        run_frame(1'b1, 1'b0, 100, 100);
        do_reset(2);
        run_frame(1'b1, 1'b0, 100, 100);

        // 5x4 random frames with random valid/ready.
        sel = 1;
        fw  = 5;
        fh  = 4;
        do_reset(2);
        repeat (6) begin
            set_frame(3);
            run_frame(1'b0, 1'b0, 50, 50);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
